// File: rtl/prog_launcher.sv
// Host-side launcher: streams operands into data memory, pulses the core, waits for halt,
// then streams results back. Optional watchdog enabled by defining LAUNCH_TIMEOUT_EN.
module prog_launcher #(
  parameter int          LOAD_WORDS     = 4,
  parameter logic [7:0]  LOAD_BASE      = 8'd0,
  parameter logic [7:0]  RESULT_BASE    = 8'd64,
  parameter int          RESULT_WORDS   = 2,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_valid,
  input  logic [7:0]  op_data,
  output logic        op_ready,
  output logic        req,
  input  logic        halt,
  output logic        dm_we,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_wdata,
  input  logic [7:0]  dm_rdata,
  output logic        res_valid,
  output logic [7:0]  res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] run_cycles,
  output logic        timed_out
);

  typedef enum logic [2:0] {
    IDLE, LOAD, KICK, RUN, RDADDR, RDCAP, OUT, FIN
  } state_t;

  localparam logic [7:0] LOAD_LAST = 8'(LOAD_WORDS - 1);
  localparam logic [7:0] RES_LAST  = 8'(RESULT_WORDS - 1);
`ifdef LAUNCH_TIMEOUT_EN
  localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);
`endif

  state_t     state;
  logic [7:0] idx;

  // Memory port must reflect the operand handshake in the same cycle, so it is decoded combinationally.
  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    unique case (state)
      LOAD: begin
        dm_addr = LOAD_BASE + idx;
        if (op_valid) begin
          dm_we    = 1'b1;
          dm_wdata = op_data;
        end
      end
      RDADDR, RDCAP: dm_addr = RESULT_BASE + idx;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      run_cycles <= '0;
      timed_out  <= 1'b0;
      res_data   <= '0;
      req        <= 1'b0;
      op_ready   <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      req  <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            run_cycles <= '0;
            timed_out  <= 1'b0;
            busy       <= 1'b1;
            if (LOAD_WORDS == 0) begin
              state <= KICK;
              req   <= 1'b1;
            end else begin
              state    <= LOAD;
              op_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (op_valid) begin
            if (idx == LOAD_LAST) begin
              idx      <= '0;
              op_ready <= 1'b0;
              req      <= 1'b1;
              state    <= KICK;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        KICK: state <= RUN;
        RUN: begin
          if (halt) begin
            idx <= '0;
            if (RESULT_WORDS == 0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RDADDR;
            end
          end else begin
            if (run_cycles != '1) run_cycles <= run_cycles + 16'd1;
`ifdef LAUNCH_TIMEOUT_EN
            if ({1'b0, run_cycles} + 17'd1 >= TO_LIMIT) begin
              timed_out <= 1'b1;
              state     <= FIN;
              done      <= 1'b1;
            end
`endif
          end
        end
        RDADDR: state <= RDCAP;
        RDCAP: begin
          res_data  <= dm_rdata;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (idx == RES_LAST) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 8'd1;
              state <= RDADDR;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_launcher.sv
// Randomized bench for prog_launcher: host/core/memory environment plus a reference of the
// expected operand writes, run length and result stream for each launch.
module tb_prog_launcher;

  localparam int         LW = 4;
  localparam logic [7:0] LB = 8'd0;
  localparam logic [7:0] RB = 8'd64;
  localparam int         RW = 2;
`ifdef LAUNCH_TIMEOUT_EN
  localparam int         TO = 20;
`else
  localparam int         TO = 4096;
`endif

  logic        clk = 1'b0;
  logic        reset, start, op_valid, halt, res_ready;
  logic [7:0]  op_data, dm_rdata, dm_addr, dm_wdata, res_data;
  logic        op_ready, req, dm_we, res_valid, busy, done, timed_out;
  logic [15:0] run_cycles;

  always #5 clk = ~clk;

  prog_launcher #(
    .LOAD_WORDS(LW), .LOAD_BASE(LB), .RESULT_BASE(RB),
    .RESULT_WORDS(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .req(req), .halt(halt),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .done(done), .run_cycles(run_cycles), .timed_out(timed_out)
  );

  // Environment: synchronous-read result memory, write log, req pulse counter.
  logic [7:0]  res_mem [256];
  logic [15:0] wr_q [$];
  int          req_cnt = 0;
  logic [7:0]  ops [LW];

  always @(posedge clk) begin
    if (dm_we) wr_q.push_back({dm_addr, dm_wdata});
    dm_rdata <= res_mem[dm_addr];
  end

  always @(negedge clk) if (req) req_cnt++;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_reset_state(input string where);
    check_eq({where, ".ctl"}, {25'd0, req, op_ready, dm_we, res_valid, busy, done, timed_out}, 32'd0);
    check_eq({where, ".dm_addr"}, {24'd0, dm_addr}, 32'd0);
    check_eq({where, ".dm_wdata"}, {24'd0, dm_wdata}, 32'd0);
    check_eq({where, ".res_data"}, {24'd0, res_data}, 32'd0);
    check_eq({where, ".run_cycles"}, {16'd0, run_cycles}, 32'd0);
  endtask

  task automatic do_reset(input string where);
    start = 1'b0; halt = 1'b0; res_ready = 1'b0; op_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_reset_state(where);
  endtask

  // Start a launch and stream the operands with random gaps; returns in the KICK cycle.
  task automatic do_load(input int q0);
    int i, k;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("busy_on_start", {31'd0, busy}, 32'd1);
    check_eq("op_ready_load", {31'd0, op_ready}, 32'd1);
    check_eq("timed_out_clr", {31'd0, timed_out}, 32'd0);
    check_eq("run_cycles_clr", {16'd0, run_cycles}, 32'd0);
    i = 0; k = 0;
    while (i < LW && k < 200) begin
      op_valid = ($urandom_range(2) != 0);
      op_data  = op_valid ? ops[i] : 8'($urandom);
      @(negedge clk);
      if (op_valid) i++;
      k++;
    end
    op_valid = 1'b0;
    check_eq("req_after_load", {31'd0, req}, 32'd1);
    check_eq("op_ready_drop", {31'd0, op_ready}, 32'd0);
    check_eq("write_count", wr_q.size() - q0, LW);
    for (int j = 0; j < LW && q0 + j < wr_q.size(); j++)
      check_eq("write_entry", {16'd0, wr_q[q0 + j]}, {16'd0, 8'(LB + j), ops[j]});
  endtask

  // abort: 0 = full launch, 1 = reset mid-RUN, 2 = reset while presenting the first result
  task automatic launch(input int n_run, input int min_stall, input int max_stall,
                        input bit stale, input int abort);
    int q0, r0, k, s;
    logic [7:0] exp_d;
    q0 = wr_q.size(); r0 = req_cnt;
    do_load(q0);
    halt = stale;
    @(negedge clk);
    halt = 1'b0;
    check_eq("req_one_cycle", {31'd0, req}, 32'd0);
    for (k = 0; k < n_run; k++) begin
      if (abort == 1 && k == n_run / 2) begin
        do_reset("rst_in_run");
        return;
      end
      start = $urandom_range(1);
      @(negedge clk);
    end
    start = 1'b0;
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check_eq("run_cycles", {16'd0, run_cycles}, n_run);
    check_eq("req_pulses", req_cnt - r0, 1);
    for (int r = 0; r < RW; r++) begin
      exp_d = res_mem[8'(RB + r)];
      k = 0;
      while (!res_valid && k < 8) begin @(negedge clk); k++; end
      check_eq("res_valid_wait", {31'd0, res_valid}, 32'd1);
      check_eq("res_data", {24'd0, res_data}, {24'd0, exp_d});
      if (abort == 2) begin
        do_reset("rst_in_out");
        return;
      end
      s = $urandom_range(max_stall, min_stall);
      repeat (s) begin
        res_ready = 1'b0;
        @(negedge clk);
        check_eq("res_hold_valid", {31'd0, res_valid}, 32'd1);
        check_eq("res_hold_data", {24'd0, res_data}, {24'd0, exp_d});
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check_eq("res_valid_drop", {31'd0, res_valid}, 32'd0);
    end
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("busy_in_fin", {31'd0, busy}, 32'd1);
    check_eq("timed_out_norm", {31'd0, timed_out}, 32'd0);
    @(negedge clk);
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("busy_idle", {31'd0, busy}, 32'd0);
    check_eq("total_writes", wr_q.size() - q0, LW);
  endtask

  task automatic rand_setup();
    for (int j = 0; j < LW; j++) ops[j] = 8'($urandom);
    for (int j = 0; j < RW; j++) res_mem[8'(RB + j)] = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_valid = 1'b0; op_data = '0; halt = 1'b0; res_ready = 1'b0;
    for (int j = 0; j < 256; j++) res_mem[j] = 8'($urandom);
    repeat (3) @(negedge clk);
    expect_reset_state("por");
    reset = 1'b0;
    @(negedge clk);
    expect_reset_state("idle");

    ops[0] = 8'd11; ops[1] = 8'd22; ops[2] = 8'd33; ops[3] = 8'd44;
    res_mem[RB] = 8'hA5; res_mem[8'(RB + 1)] = 8'h5A;
    launch(10, 5, 5, 1'b1, 0);

    for (int n = 0; n < 6; n++) begin
      rand_setup();
      launch($urandom_range(15), 0, 3, 1'($urandom_range(1)), 0);
    end

    rand_setup();
    launch(8, 0, 0, 1'b0, 1);
    rand_setup();
    launch(5, 0, 2, 1'b0, 0);
    rand_setup();
    launch(4, 0, 0, 1'b0, 2);
    rand_setup();
    launch(3, 0, 2, 1'b1, 0);

`ifdef LAUNCH_TIMEOUT_EN
    begin
      int cnt;
      rand_setup();
      do_load(wr_q.size());
      halt = 1'b0;
      cnt = 0;
      while (!done && cnt < 100) begin
        check_eq("to_no_result", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        cnt++;
      end
      check_eq("to_run_len", cnt - 1, TO);
      check_eq("to_run_cycles", {16'd0, run_cycles}, TO);
      check_eq("to_flag", {31'd0, timed_out}, 32'd1);
      @(negedge clk);
      check_eq("to_flag_idle", {31'd0, timed_out}, 32'd1);
      rand_setup();
      launch(6, 0, 1, 1'b0, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
